blackparrot_fpga_host_mmio_serializer: RTL
==========================================

Name: blackparrot_fpga_host_mmio_serializer

Overview:
- Sits between the BP S_AXI I/O-out capture logic and the host-readable MMIO CSRs (out-buffer data and out-buffer count).
- Accepts one decoded BP MMIO request per handshake (address, data, size, write flag).
- Serializes each request into 32b words and stores them in a circular word buffer.
- Exposes the buffer head word and its occupancy count through FIFO-style interfaces that the AXI-Lite CSR read path consumes.

Parameters:
- addr_width_p, 64, request address width; must be 64
- data_width_p, 64, request data width; must be 64
- word_width_p, 32, serialized word width; must be 32
- els_p, 64, buffer depth in words; power of 2, >= 8

Ports:
- clk_i  in  1  single clock for all logic
- reset_i  in  1  asynchronous, active-high reset
- req_v_i  in  1  request valid
- req_ready_and_o  out  1  request ready (valid-and-ready handshake)
- req_we_i  in  1  1 = write, 0 = read
- req_size_i  in  2  log2 of byte size (0 = 1B .. 3 = 8B)
- req_addr_i  in  addr_width_p  request address
- req_data_i  in  data_width_p  write data, LSB-aligned
- word_v_o  out  1  buffer non-empty
- word_o  out  word_width_p  buffer head word
- word_yumi_i  in  1  pop head word; only legal when word_v_o = 1
- count_v_o  out  1  count valid; constant 1 out of reset
- count_o  out  word_width_p  words in buffer, zero-extended
- count_yumi_i  in  1  count read acknowledge; no side effect

Behaviour:
- Reset values:
  - FSM = IDLE; buffer read/write pointers and count = 0.
  - req_ready_and_o = 0 while reset_i is high, 1 the first cycle after.
  - word_v_o = 0; count_o = 0; count_v_o = 0 during reset, 1 after.
- FSM states:
  - IDLE: req_ready_and_o = 1. On req_v_i & req_ready_and_o, latch we, size, addr, data.
    - Data latch masks bytes above 2^size to 0.
    - Clear word index to 0; go to EMIT.
  - EMIT: req_ready_and_o = 0. Each cycle in which the buffer is not full, push word[index] and increment index. After pushing the last word, return to IDLE. Ready is reasserted the following cycle; there is no same-cycle re-accept.
- Word sequence and length N:
  - word0 header: [31] = we, [30:29] = size, [28:3] = 0, [2:0] = N.
  - word1 = addr[31:0]; word2 = addr[63:32].
  - word3 = data[31:0] (writes only).
  - word4 = data[63:32] (writes with size = 3 only).
  - N = 3 for reads, 4 for writes with size < 3, 5 for writes with size = 3.
- Full stall: when count == els_p, no push occurs; index and FSM hold with no word lost or duplicated. A push is never accepted on full, even if a pop happens the same cycle (no full-bypass).
- Pop: on word_yumi_i, the read pointer advances by 1 modulo els_p. Pointers wrap naturally (els_p is a power of 2).
- Count arithmetic: count width = $clog2(els_p+1).
  - Push only: +1. Pop only: -1. Push and pop together: unchanged.
- word_o is combinational from the read pointer; latency from push to word_v_o is 1 cycle (registered storage, no bypass).
- word_yumi_i while empty is illegal: state is unchanged and a simulation assertion fires.
- Reset mid-EMIT discards the latched request and all buffered words. Nothing is emitted after reset deasserts.

Test Plan:
1. Write, size 3, addr 0x0000_0010_8000_1000, data 0x1122_3344_5566_7788, host pops every cycle -> words in order 0xE000_0005, 0x8000_1000, 0x0000_0010, 0x5566_7788, 0x1122_3344. count_o peaks at 1 or 2; req_ready_and_o returns to 1 six cycles after the accept.
2. Read, size 2, addr 0x100, no pops -> 3 words 0x4000_0003, 0x0000_0100, 0x0000_0000; count_o = 3; no data words.
3. Write, size 0, data 0xFFFF_FFFF_FFFF_FFAB -> data word 0x0000_00AB, header 0x8000_0004, N = 4.
4. els_p = 8, no pops, two size-3 writes -> second request stalls in EMIT with count_o = 8 after 3 of its 5 words. One pop per cycle then releases the remaining 2 words; the full sequence is intact and the read pointer wraps past 7 to 0.
5. Push and pop in the same cycle at count = 4 -> count_o stays 4. Pop while empty -> count_o stays 0 and the assertion fires.
6. Assert reset_i mid-EMIT after 2 words -> next cycle word_v_o = 0, count_o = 0, req_ready_and_o = 1 after reset deasserts, and no stale words appear.

Source files
------------

// File: rtl/blackparrot_fpga_host_mmio_serializer.sv
// Serializes decoded BP MMIO requests into 32b words held in a circular buffer
// that the host drains through the out-buffer data/count CSRs.
module blackparrot_fpga_host_mmio_serializer #(
    parameter int addr_width_p = 64,
    parameter int data_width_p = 64,
    parameter int word_width_p = 32,
    parameter int els_p        = 64
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    req_v_i,
    output logic                    req_ready_and_o,
    input  logic                    req_we_i,
    input  logic [1:0]              req_size_i,
    input  logic [addr_width_p-1:0] req_addr_i,
    input  logic [data_width_p-1:0] req_data_i,
    output logic                    word_v_o,
    output logic [word_width_p-1:0] word_o,
    input  logic                    word_yumi_i,
    output logic                    count_v_o,
    output logic [word_width_p-1:0] count_o,
    input  logic                    count_yumi_i
);
    localparam int ptr_w_lp = $clog2(els_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);

    typedef enum logic {IDLE, EMIT} state_e;

    state_e                    state_q, state_d;
    logic                      we_q, we_d;
    logic [1:0]                size_q, size_d;
    logic [addr_width_p-1:0]   addr_q, addr_d;
    logic [data_width_p-1:0]   data_q, data_d;
    logic [2:0]                idx_q, idx_d;
    logic [ptr_w_lp-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cnt_w_lp-1:0]       count_q, count_d;
    logic [word_width_p-1:0]   mem_q [els_p];

    logic                      full, push, pop, req_fire;
    logic [2:0]                n_words;
    logic [word_width_p-1:0]   word_mux;
    logic [data_width_p-1:0]   size_mask;
    logic                      unused_count_yumi;

    // The count CSR read has no side effect, so its acknowledge is ignored.
    assign unused_count_yumi = count_yumi_i;

    assign req_ready_and_o = (state_q == IDLE) && !reset_i;
    assign count_v_o       = !reset_i;
    assign req_fire        = req_v_i && req_ready_and_o;
    assign full            = (count_q == cnt_w_lp'(els_p));
    assign push            = (state_q == EMIT) && !full;
    assign pop             = word_yumi_i && (count_q != '0);
    assign word_v_o        = (count_q != '0);
    assign word_o          = mem_q[rptr_q];
    assign count_o         = word_width_p'(count_q);
    assign n_words         = !we_q ? 3'd3 : ((size_q == 2'd3) ? 3'd5 : 3'd4);

    always_comb begin
        case (req_size_i)
            2'd0:    size_mask = 64'h0000_0000_0000_00FF;
            2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    always_comb begin
        case (idx_q)
            3'd0:    word_mux = {we_q, size_q, 26'b0, n_words};
            3'd1:    word_mux = addr_q[31:0];
            3'd2:    word_mux = addr_q[63:32];
            3'd3:    word_mux = data_q[31:0];
            default: word_mux = data_q[63:32];
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        data_d  = data_q;
        idx_d   = idx_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    we_d    = req_we_i;
                    size_d  = req_size_i;
                    addr_d  = req_addr_i;
                    data_d  = req_data_i & size_mask;
                    idx_d   = 3'd0;
                    state_d = EMIT;
                end
            end
            default: begin
                // A full buffer holds the index so the stalled word is retried.
                if (push) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == n_words - 3'd1) state_d = IDLE;
                end
            end
        endcase
        if (push) wptr_d = wptr_q + ptr_w_lp'(1);
        if (pop)  rptr_d = rptr_q + ptr_w_lp'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + cnt_w_lp'(1);
            2'b01:   count_d = count_q - cnt_w_lp'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            data_q  <= '0;
            idx_q   <= 3'd0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: occupancy is tracked solely by count_q.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= word_mux;
    end

    no_pop_when_empty: assert property (@(posedge clk_i) disable iff (reset_i)
        word_yumi_i |-> word_v_o);

endmodule
